// File: rtl/uart_flag_pkg.sv
// ---------------------------------------------------------------------------
// uart_flag_pkg
// Shared definitions for the UART frame checker slice:
//   - FSM state encodings and the state enum built on them
//   - width helpers for the byte index and the consecutive-failure counter
//   - default frame geometry and the default expected frame, shared with the
//     TX stimulus generator in the board top level
// ---------------------------------------------------------------------------
package uart_flag_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COMPARE = 2'd1;
   localparam logic [1:0] ST_RESULT  = 2'd2;
   localparam logic [1:0] ST_LOCKOUT = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      COMPARE = ST_COMPARE,
      RESULT  = ST_RESULT,
      LOCKOUT = ST_LOCKOUT
   } state_t;

   localparam int DEF_FRAME_BYTES = 18;
   localparam int DEF_DBITS       = 8;

   localparam logic [DEF_FRAME_BYTES*DEF_DBITS-1:0] DEFAULT_EXPECTED = '0;

   // Wide enough to hold 0..frame_bytes (frame_bytes means "no bad byte").
   function automatic int idx_w(input int frame_bytes);
      return $clog2(frame_bytes + 1);
   endfunction

   // Wide enough to hold 0..max_fails.
   function automatic int fail_w(input int max_fails);
      return $clog2(max_fails + 1);
   endfunction

endpackage

// File: rtl/uart_flag_checker_if.sv
// ---------------------------------------------------------------------------
// uart_flag_checker_if
// Frame hand-off between the UART RX path and the flag checker.
//   frame_valid : a complete frame is waiting (~rx_empty)
//   frame_in    : frame data, byte 0 in the MSB byte
//   frame_ack   : one-cycle pop strobe back to the RX side
// master = frame source, slave = checker.
// ---------------------------------------------------------------------------
interface uart_flag_checker_if
   import uart_flag_pkg::*;
#(
   parameter int FRAME_BYTES = DEF_FRAME_BYTES,
   parameter int DBITS       = DEF_DBITS
) ();

   logic                         frame_valid;
   logic [FRAME_BYTES*DBITS-1:0] frame_in;
   logic                         frame_ack;

   modport master (output frame_valid, output frame_in, input frame_ack);
   modport slave  (input frame_valid, input frame_in, output frame_ack);

endinterface

// File: rtl/uart_lockout_timer.sv
// ---------------------------------------------------------------------------
// uart_lockout_timer
// Loadable down-counter timing the lockout window.
//   clk, rst : clock, synchronous active-high reset
//   start    : load LOCKOUT_CYCLES-1 and become active
//   active   : counting in progress
//   done     : active and count has reached zero (last lockout cycle)
// ---------------------------------------------------------------------------
module uart_lockout_timer #(
   parameter int LOCKOUT_CYCLES = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic active,
   output logic done
);

   localparam int            CW   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LOAD = CW'(LOCKOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         cnt_q  <= '0;
      end else if (start) begin
         active <= 1'b1;
         cnt_q  <= LOAD;
      end else if (active) begin
         if (cnt_q == '0) begin
            active <= 1'b0;
         end else begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   assign done = active && (cnt_q == '0);

endmodule

// File: rtl/uart_flag_checker.sv
// ---------------------------------------------------------------------------
// uart_flag_checker
// Takes frames from the UART RX path and compares them, one byte per cycle,
// against EXPECTED. Emits a one-cycle match/mismatch verdict, a sticky
// unlocked flag and a consecutive-failure count; MAX_FAILS consecutive
// failures start a LOCKOUT_CYCLES-long lockout during which frames are
// drained without a verdict.
//   clk_100MHz, reset : clock, synchronous active-high reset
//   fr (slave)        : frame_valid / frame_in in, frame_ack out
//   busy              : FSM not in IDLE
//   match, mismatch   : one-cycle verdict pulses
//   unlocked          : sticky, set by any match
//   locked_out        : high during lockout
//   fail_count        : consecutive mismatches (saturates at MAX_FAILS)
//   first_bad_idx     : first differing byte of last verdict, FRAME_BYTES if none
// ---------------------------------------------------------------------------
module uart_flag_checker
   import uart_flag_pkg::*;
#(
   parameter int                           FRAME_BYTES    = DEF_FRAME_BYTES,
   parameter int                           DBITS          = DEF_DBITS,
   parameter logic [FRAME_BYTES*DBITS-1:0] EXPECTED       = DEFAULT_EXPECTED,
   parameter int                           MAX_FAILS      = 3,
   parameter int                           LOCKOUT_CYCLES = 100_000_000
) (
   input  logic                             clk_100MHz,
   input  logic                             reset,
   uart_flag_checker_if.slave               fr,
   output logic                             busy,
   output logic                             match,
   output logic                             mismatch,
   output logic                             unlocked,
   output logic                             locked_out,
   output logic [fail_w(MAX_FAILS)-1:0]     fail_count,
   output logic [idx_w(FRAME_BYTES)-1:0]    first_bad_idx
);

   localparam int             IW   = idx_w(FRAME_BYTES);
   localparam int             FW   = fail_w(MAX_FAILS);
   localparam int             XW   = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam logic [XW-1:0]  LAST = XW'(FRAME_BYTES - 1);
   localparam logic [IW-1:0]  NONE = IW'(FRAME_BYTES);
   localparam logic [FW-1:0]  MAXF = FW'(MAX_FAILS);

   state_t            state_q, state_nxt;
   logic [DBITS-1:0]  in_b     [FRAME_BYTES];
   logic [DBITS-1:0]  exp_b    [FRAME_BYTES];
   logic [DBITS-1:0]  shadow_b [FRAME_BYTES];
   logic [XW-1:0]     idx_q;
   logic              diff_q, diff_nxt, byte_diff;
   logic [IW-1:0]     bad_q, bad_nxt;
   logic              scan_last;
   logic              timer_start, timer_active, timer_done;

   // Byte 0 is the MSB byte of the packed frame (first character on the wire).
   for (genvar i = 0; i < FRAME_BYTES; i++) begin : g_bytes
      assign in_b[i]  = fr.frame_in[(FRAME_BYTES-1-i)*DBITS +: DBITS];
      assign exp_b[i] = EXPECTED[(FRAME_BYTES-1-i)*DBITS +: DBITS];
   end

   uart_lockout_timer #(
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
   ) u_timer (
      .clk    (clk_100MHz),
      .rst    (reset),
      .start  (timer_start),
      .active (timer_active),
      .done   (timer_done)
   );

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state_q;
      fr.frame_ack = 1'b0;
      timer_start  = 1'b0;
      byte_diff    = (shadow_b[idx_q] != exp_b[idx_q]);
      diff_nxt     = diff_q | byte_diff;
      bad_nxt      = (byte_diff && (bad_q == NONE)) ? IW'(idx_q) : bad_q;
      scan_last    = (state_q == COMPARE) && (idx_q == LAST);
      case (state_q)
         IDLE: begin
            if (fr.frame_valid) begin
               fr.frame_ack = 1'b1;
               state_nxt    = COMPARE;
            end
         end
         COMPARE: begin
            if (idx_q == LAST) state_nxt = RESULT;
         end
         RESULT: begin
            // fail_count already holds the post-verdict value here.
            if (mismatch && (fail_count == MAXF)) begin
               state_nxt   = LOCKOUT;
               timer_start = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         LOCKOUT: begin
            fr.frame_ack = fr.frame_valid;
            if (timer_done || !timer_active) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Scan datapath: no reset, every capture reinitialises it.
   always_ff @(posedge clk_100MHz) begin
      if ((state_q == IDLE) && fr.frame_valid) begin
         shadow_b <= in_b;
         idx_q    <= '0;
         diff_q   <= 1'b0;
         bad_q    <= NONE;
      end else if (state_q == COMPARE) begin
         idx_q  <= idx_q + XW'(1);
         diff_q <= diff_nxt;
         bad_q  <= bad_nxt;
      end
   end

   // Verdict outputs are registered on the last scan cycle so they are
   // visible during the single RESULT cycle.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         busy          <= 1'b0;
         match         <= 1'b0;
         mismatch      <= 1'b0;
         unlocked      <= 1'b0;
         locked_out    <= 1'b0;
         fail_count    <= '0;
         first_bad_idx <= NONE;
      end else begin
         busy       <= (state_nxt != IDLE);
         locked_out <= (state_nxt == LOCKOUT);
         match      <= 1'b0;
         mismatch   <= 1'b0;
         if (scan_last) begin
            first_bad_idx <= bad_nxt;
            if (diff_nxt) begin
               mismatch <= 1'b1;
               if (fail_count != MAXF) fail_count <= fail_count + FW'(1);
            end else begin
               match      <= 1'b1;
               unlocked   <= 1'b1;
               fail_count <= '0;
            end
         end
         if ((state_q == LOCKOUT) && (state_nxt == IDLE)) fail_count <= '0;
      end
   end

endmodule

// File: tb/tb_uart_flag_checker.sv
module tb_uart_flag_checker;

   localparam int          FB   = 4;
   localparam logic [31:0] GOOD = 32'h7b41427d;
   localparam logic [31:0] BAD2 = 32'h7b41007d;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       busy, match, mismatch, unlocked, locked_out;
   logic [1:0] fail_count;
   logic [2:0] first_bad_idx;

   int cyc      = 0;
   int errors   = 0;
   int checks   = 0;
   int last_ack = 0;
   int prev_ack = 0;
   int a_cyc    = 0;
   int n        = 0;

   typedef struct {
      bit m;
      int bad;
      int fc;
      bit unl;
      int due;
   } exp_t;

   exp_t q[$];

   uart_flag_checker_if #(.FRAME_BYTES(FB), .DBITS(8)) fr ();

   uart_flag_checker #(
      .FRAME_BYTES    (FB),
      .DBITS          (8),
      .EXPECTED       (GOOD),
      .MAX_FAILS      (3),
      .LOCKOUT_CYCLES (16)
   ) dut (
      .clk_100MHz    (clk),
      .reset         (reset),
      .fr            (fr),
      .busy          (busy),
      .match         (match),
      .mismatch      (mismatch),
      .unlocked      (unlocked),
      .locked_out    (locked_out),
      .fail_count    (fail_count),
      .first_bad_idx (first_bad_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string name, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endfunction

   // Monitor: pops the oldest expectation whenever a verdict pulse appears.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0 && (match === 1'b1 || mismatch === 1'b1)) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_verdict: match=%0b mismatch=%0b with nothing pending (cycle %0d)",
                     match, mismatch, cyc);
         end else begin
            e = q.pop_front();
            chk("v_match", int'(match), int'(e.m));
            chk("v_mismatch", int'(mismatch), int'(!e.m));
            chk("v_first_bad_idx", int'(first_bad_idx), e.bad);
            chk("v_fail_count", int'(fail_count), e.fc);
            chk("v_unlocked", int'(unlocked), int'(e.unl));
            chk("v_cycle", cyc, e.due);
         end
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_match"}, int'(match), 0);
      chk({tag, "_mismatch"}, int'(mismatch), 0);
      chk({tag, "_unlocked"}, int'(unlocked), 0);
      chk({tag, "_locked_out"}, int'(locked_out), 0);
      chk({tag, "_fail_count"}, int'(fail_count), 0);
      chk({tag, "_first_bad_idx"}, int'(first_bad_idx), FB);
   endtask

   // Presents a frame, waits (bounded) for the ack, queues the expected
   // verdict and returns just after the capture edge.
   task automatic send(input logic [31:0] d, input bit hold, input bit chk_v,
                       input bit em, input int eb, input int efc, input bit eu);
      int waited;
      waited         = 0;
      fr.frame_valid = 1'b1;
      fr.frame_in    = d;
      #1;
      while (fr.frame_ack !== 1'b1 && waited < 60) begin
         @(posedge clk);
         #1;
         waited++;
      end
      chk("ack_seen", int'(fr.frame_ack === 1'b1), 1);
      prev_ack = last_ack;
      last_ack = cyc;
      if (chk_v) q.push_back('{em, eb, efc, eu, cyc + 5});
      @(posedge clk);
      #1;
      fr.frame_in = ~d;
      if (!hold) fr.frame_valid = 1'b0;
   endtask

   initial begin
      fr.frame_valid = 1'b0;
      fr.frame_in    = '0;

      // Reset
      wait_cyc(3);
      reset = 1'b0;
      check_reset_vals("reset");

      // Match, presented at cycle 10
      wait_cyc(10);
      send(GOOD, 1'b0, 1'b1, 1'b1, 4, 0, 1'b1);
      chk("match_ack_cycle", last_ack, 10);
      wait_cyc(last_ack + 6);
      chk("match_idle_busy", int'(busy), 0);

      // Single mismatch at byte 2
      send(BAD2, 1'b0, 1'b1, 1'b0, 2, 1, 1'b1);
      wait_cyc(last_ack + 6);
      send(GOOD, 1'b0, 1'b1, 1'b1, 4, 0, 1'b1);
      wait_cyc(last_ack + 6);

      // Three consecutive failures -> lockout
      send(32'h0, 1'b0, 1'b1, 1'b0, 0, 1, 1'b1);
      send(32'h0, 1'b0, 1'b1, 1'b0, 0, 2, 1'b1);
      send(32'h0, 1'b0, 1'b1, 1'b0, 0, 3, 1'b1);
      a_cyc = last_ack;
      wait_cyc(a_cyc + 5);
      chk("lock_pre", int'(locked_out), 0);
      wait_cyc(a_cyc + 6);
      n = 0;
      while (locked_out === 1'b1 && n < 40) begin
         chk("lock_fc", int'(fail_count), 3);
         if (n == 4) begin
            fr.frame_valid = 1'b1;
            fr.frame_in    = 32'h12345678;
            #1;
            chk("lock_drain_ack", int'(fr.frame_ack), 1);
         end else begin
            fr.frame_valid = 1'b0;
         end
         n++;
         @(posedge clk);
         #1;
      end
      fr.frame_valid = 1'b0;
      chk("lock_len", n, 16);
      chk("lock_fc_clear", int'(fail_count), 0);
      send(GOOD, 1'b0, 1'b1, 1'b1, 4, 0, 1'b1);
      chk("post_lock_ack", last_ack, a_cyc + 22);
      wait_cyc(last_ack + 6);

      // Back-to-back with valid held high
      send(GOOD, 1'b1, 1'b1, 1'b1, 4, 0, 1'b1);
      send(BAD2, 1'b1, 1'b1, 1'b0, 2, 1, 1'b1);
      chk("b2b_gap1", last_ack - prev_ack, 6);
      send(GOOD, 1'b1, 1'b1, 1'b1, 4, 0, 1'b1);
      chk("b2b_gap2", last_ack - prev_ack, 6);
      send(BAD2, 1'b0, 1'b1, 1'b0, 2, 1, 1'b1);
      chk("b2b_gap3", last_ack - prev_ack, 6);
      wait_cyc(last_ack + 8);

      // Reset in the middle of a compare
      send(GOOD, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      a_cyc = last_ack;
      wait_cyc(a_cyc + 2);
      reset = 1'b1;
      wait_cyc(a_cyc + 3);
      reset = 1'b0;
      check_reset_vals("midrst");
      wait_cyc(a_cyc + 10);
      chk("midrst_still_idle", int'(busy), 0);
      send(GOOD, 1'b0, 1'b1, 1'b1, 4, 0, 1'b1);
      wait_cyc(last_ack + 6);

      // Several differing bytes: first one reported, same latency
      send(32'h7b00007d, 1'b0, 1'b1, 1'b0, 1, 1, 1'b1);
      wait_cyc(last_ack + 6);
      send(32'hff41427d, 1'b0, 1'b1, 1'b0, 0, 2, 1'b1);

      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("queue_drain", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
